tck7_gmii_tx_arbiter: RTL and testbench
=======================================

Name: tck7_gmii_tx_arbiter

Overview:
- Shares one GMII TX port between two frame sources: source 0 is the UDP beacon generator and source 1 is the user MAC/streaming path.
- Sits between those sources and the PCS/PMA GMII TX input, in the same 125 MHz GMII clock domain.
- Grants the port one whole frame at a time and enforces the minimum inter-frame gap.
- Aborts frames that run too long and counts frames sent and frames aborted.

Parameters:
- ARB_MODE, 0, arbitration policy: 0 = fixed priority (source 0 wins); 1 = round-robin (the source not served last wins a tie).
- IFG_LEN, 12, number of idle cycles forced after every frame end or abort; legal range 1..255.
- MAX_LEN, 1526, maximum number of tx_en-high bytes per frame, preamble included, before the frame is aborted.
- START_TMO, 16, number of cycles a granted source has to raise tx_en before its grant is revoked.

Ports:
- clk  in  1  GMII TX clock.
- reset_n  in  1  reset, asynchronous assert, active-low.
- s0_req  in  1  source 0 requests the port; level signal, held until the frame starts.
- s0_gnt  out  1  source 0 owns the port.
- s0_tx_en  in  1  source 0 GMII TX enable.
- s0_tx_er  in  1  source 0 GMII TX error.
- s0_txd  in  8  source 0 GMII TX data.
- s1_req, s1_gnt, s1_tx_en, s1_tx_er, s1_txd  same as the source 0 ports, for source 1.
- gmii_tx_en  out  1  to PCS.
- gmii_tx_er  out  1  to PCS.
- gmii_txd  out  8  to PCS.
- frm_cnt0  out  16  frames from source 0 completed without abort; wraps.
- frm_cnt1  out  16  frames from source 1 completed without abort; wraps.
- abort_cnt  out  16  frames aborted by the length watchdog, either source; wraps.

Behaviour:
- Reset (reset_n=0, asynchronous):
  - state goes to S_IDLE.
  - All outputs are 0: gnt, gmii_*, and all counters.
  - The round-robin pointer resets to prefer source 0.
  - Reset mid-frame truncates the frame immediately. No tx_er is emitted.
- States:
  - S_IDLE:
    - No request: stay in S_IDLE.
    - Any request: arbitrate per ARB_MODE, assert the winner's gnt on the next cycle, go to S_WAIT.
  - S_WAIT:
    - Granted tx_en=1: go to S_TX.
    - No tx_en within START_TMO cycles of the grant: drop gnt, go to S_IFG. No counter changes.
  - S_TX:
    - Granted tx_en=0: frame end. Increment that source's frm_cnt, go to S_IFG.
    - Byte count reaches MAX_LEN while tx_en is still 1: abort.
  - Abort:
    - The MAX_LEN-th byte is followed by one byte with gmii_tx_er=1 and gmii_tx_en=1.
    - Then force gmii_tx_en=0, increment abort_cnt, go to S_DRAIN.
  - S_DRAIN:
    - Outputs stay idle.
    - Wait for the granted tx_en to go to 0, then go to S_IFG.
  - S_IFG:
    - gnt=0, outputs idle, for exactly IFG_LEN cycles.
    - Then go to S_IDLE. A request pending at that point is arbitrated on that S_IDLE cycle.
- gnt:
  - Is 1 from the cycle after arbitration until the frame end or abort is detected.
  - Falls in the same cycle as the S_IFG or S_DRAIN transition.
- Datapath:
  - gmii_* are registered copies of the granted source's inputs: latency exactly 1 cycle, whole frame passed byte for byte.
  - Outside S_TX, gmii_tx_en=0, gmii_tx_er=0, gmii_txd=8'h00.
  - The non-granted source's inputs are ignored at all times.
- Byte counter:
  - 11 bits, saturating; counts granted tx_en=1 cycles in S_TX.
  - MAX_LEN=0 disables the watchdog.
- Round-robin pointer:
  - Updates on every grant.
  - With only one requester, that source wins regardless of the pointer.
- Simultaneous events:
  - Both requests in the same S_IDLE cycle: the policy decides.
  - A request that drops before its grant appears is still granted, then times out via START_TMO.
  - Counter increment together with wrap: 16'hFFFF goes to 16'h0000.

Decomposition:
- Shared package tck7_gmii_pkg holds:
  - the state enum (S_IDLE, S_WAIT, S_TX, S_DRAIN, S_IFG);
  - the GMII struct {tx_en, tx_er, txd[7:0]};
  - the constant GMII_IDLE.
- One sub-module, tck7_rr_arb2: a 2-requester arbiter with a mode input and pointer update on grant, purely one-hot grant logic.

Test Plan:
- Only s0_req, 194-byte beacon frame → s0_gnt=1 within 1 cycle. gmii_* reproduces the frame bytes delayed 1 cycle. frm_cnt0=1. Next grant no earlier than 12 cycles after the frame end.
- s0_req and s1_req asserted together, ARB_MODE=0 → source 0 served first, source 1 served after IFG. ARB_MODE=1, repeated → grants alternate 0,1,0,1. frm_cnt0=frm_cnt1=2 after 4 frames.
- Source 1 holds tx_en for 2000 bytes, MAX_LEN=1526 → byte 1527 carries tx_er=1. tx_en=0 afterwards. abort_cnt=1, frm_cnt1 unchanged. s1_gnt low until source 1 deasserts tx_en, then 12 idle cycles.
- Source 0 granted but never raises tx_en → gnt drops after 16 cycles. 12-cycle IFG follows. Pending source 1 is then granted. No counter changes.
- Source 1 drives tx_en=1 with random data while source 0 owns the port → gmii_txd equals only source 0 data.
- reset_n pulsed low for 3 cycles mid-frame → gmii_tx_en=0 asynchronously and all counters=0. A new request afterwards is served normally.

Source files
------------

// File: rtl/tck7_gmii_pkg.sv
// Shared types for the GMII TX arbiter: FSM states, the GMII byte bundle
// and the idle value driven toward the PCS whenever no frame is passing.
package tck7_gmii_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_TX,
    S_DRAIN,
    S_IFG
  } state_t;

  typedef struct packed {
    logic       tx_en;
    logic       tx_er;
    logic [7:0] txd;
  } gmii_t;

  localparam gmii_t GMII_IDLE = '{tx_en: 1'b0, tx_er: 1'b0, txd: 8'h00};

  // Byte counter width; the counter saturates at its all-ones value.
  localparam int BYTE_CNT_W = 11;

  // Bundle loose GMII pins into one struct.
  function automatic gmii_t gmii_pack(input logic en, input logic er, input logic [7:0] d);
    gmii_t g;
    g.tx_en = en;
    g.tx_er = er;
    g.txd   = d;
    return g;
  endfunction

endpackage

// File: rtl/tck7_rr_arb2.sv
// Two-requester arbiter. Grant is combinational and one-hot; the tie-break
// pointer remembers which source to prefer next time both request.
// mode=0: source 0 always wins a tie. mode=1: the source not served last wins.
module tck7_rr_arb2 (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       mode,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);

  logic ptr_reg;
  logic ptr_next;

  // One-hot grant: a lone requester always wins, a tie goes by mode/pointer.
  always_comb begin
    gnt = 2'b00;
    if (req == 2'b11) begin
      if (mode && ptr_reg) begin
        gnt = 2'b10;
      end else begin
        gnt = 2'b01;
      end
    end else begin
      gnt = req;
    end
  end

  // After any grant, prefer the source that did not just win.
  always_comb begin
    ptr_next = ptr_reg;
    if (advance && (gnt != 2'b00)) begin
      ptr_next = gnt[0];
    end
  end

  // Pointer register; reset prefers source 0.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr_reg <= 1'b0;
    end else begin
      ptr_reg <= ptr_next;
    end
  end

endmodule

// File: rtl/tck7_gmii_tx_arbiter.sv
// Shares one GMII TX port between the beacon generator (source 0) and the
// user MAC path (source 1). One whole frame per grant, a forced idle gap
// after every frame, a start timeout on idle grants and a length watchdog
// that terminates runaway frames with an error byte.
module tck7_gmii_tx_arbiter
  import tck7_gmii_pkg::*;
#(
  parameter int ARB_MODE  = 0,
  parameter int IFG_LEN   = 12,
  parameter int MAX_LEN   = 1526,
  parameter int START_TMO = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        s0_req,
  output logic        s0_gnt,
  input  logic        s0_tx_en,
  input  logic        s0_tx_er,
  input  logic [7:0]  s0_txd,
  input  logic        s1_req,
  output logic        s1_gnt,
  input  logic        s1_tx_en,
  input  logic        s1_tx_er,
  input  logic [7:0]  s1_txd,
  output logic        gmii_tx_en,
  output logic        gmii_tx_er,
  output logic [7:0]  gmii_txd,
  output logic [15:0] frm_cnt0,
  output logic [15:0] frm_cnt1,
  output logic [15:0] abort_cnt
);

  localparam logic                  ARB_RR    = (ARB_MODE == 1);
  localparam logic [7:0]            IFG_LAST  = 8'(IFG_LEN - 1);
  localparam logic [15:0]           TMO_LAST  = (START_TMO > 0) ? 16'(START_TMO - 1) : 16'd0;
  localparam logic [BYTE_CNT_W-1:0] MAX_LEN_C = BYTE_CNT_W'(MAX_LEN);
  localparam logic                  WD_EN     = (MAX_LEN != 0);

  state_t                  state_reg, state_next;
  logic                    owner_reg, owner_next;
  logic [1:0]              gnt_reg, gnt_next;
  gmii_t                   out_reg, out_next;
  logic [BYTE_CNT_W-1:0]   byte_cnt_reg, byte_cnt_next;
  logic [15:0]             wait_cnt_reg, wait_cnt_next;
  logic [7:0]              ifg_cnt_reg, ifg_cnt_next;
  logic [1:0]              frm_inc;
  logic                    abort_inc;
  logic [15:0]             frm_cnt_reg [2];
  logic [15:0]             abort_cnt_reg;

  gmii_t                   src_in [2];
  gmii_t                   granted_in;
  logic [1:0]              arb_gnt;

  assign src_in[0]  = gmii_pack(s0_tx_en, s0_tx_er, s0_txd);
  assign src_in[1]  = gmii_pack(s1_tx_en, s1_tx_er, s1_txd);
  // Only the owner's pins are ever looked at; the other source is ignored.
  assign granted_in = src_in[owner_reg];

  tck7_rr_arb2 u_arb (
    .clk     (clk),
    .reset_n (reset_n),
    .mode    (ARB_RR),
    .req     ({s1_req, s0_req}),
    .advance (state_reg == S_IDLE),
    .gnt     (arb_gnt)
  );

  // Next-state, grant and output-byte selection.
  always_comb begin
    state_next    = state_reg;
    owner_next    = owner_reg;
    gnt_next      = gnt_reg;
    out_next      = GMII_IDLE;
    byte_cnt_next = byte_cnt_reg;
    wait_cnt_next = wait_cnt_reg;
    ifg_cnt_next  = ifg_cnt_reg;
    frm_inc       = 2'b00;
    abort_inc     = 1'b0;

    case (state_reg)
      S_IDLE: begin
        if (arb_gnt != 2'b00) begin
          owner_next    = arb_gnt[1];
          gnt_next      = arb_gnt;
          wait_cnt_next = '0;
          state_next    = S_WAIT;
        end
      end

      S_WAIT: begin
        if (granted_in.tx_en) begin
          // First byte (preamble) is forwarded and counted as byte 1.
          out_next      = granted_in;
          byte_cnt_next = BYTE_CNT_W'(1);
          state_next    = S_TX;
        end else if (wait_cnt_reg >= TMO_LAST) begin
          gnt_next      = 2'b00;
          ifg_cnt_next  = '0;
          state_next    = S_IFG;
        end else begin
          wait_cnt_next = wait_cnt_reg + 16'd1;
        end
      end

      S_TX: begin
        if (!granted_in.tx_en) begin
          frm_inc[owner_reg] = 1'b1;
          gnt_next           = 2'b00;
          ifg_cnt_next       = '0;
          state_next         = S_IFG;
        end else if (WD_EN && (byte_cnt_reg == MAX_LEN_C)) begin
          // Byte after the last legal one goes out poisoned with tx_er.
          out_next       = granted_in;
          out_next.tx_er = 1'b1;
          abort_inc      = 1'b1;
          gnt_next       = 2'b00;
          state_next     = S_DRAIN;
        end else begin
          out_next = granted_in;
          if (byte_cnt_reg != '1) begin
            byte_cnt_next = byte_cnt_reg + BYTE_CNT_W'(1);
          end
        end
      end

      S_DRAIN: begin
        if (!granted_in.tx_en) begin
          ifg_cnt_next = '0;
          state_next   = S_IFG;
        end
      end

      S_IFG: begin
        if (ifg_cnt_reg >= IFG_LAST) begin
          state_next = S_IDLE;
        end else begin
          ifg_cnt_next = ifg_cnt_reg + 8'd1;
        end
      end

      default: begin
        gnt_next   = 2'b00;
        state_next = S_IDLE;
      end
    endcase
  end

  // FSM and datapath registers; reset truncates any frame in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg    <= S_IDLE;
      owner_reg    <= 1'b0;
      gnt_reg      <= 2'b00;
      out_reg      <= GMII_IDLE;
      byte_cnt_reg <= '0;
      wait_cnt_reg <= '0;
      ifg_cnt_reg  <= '0;
    end else begin
      state_reg    <= state_next;
      owner_reg    <= owner_next;
      gnt_reg      <= gnt_next;
      out_reg      <= out_next;
      byte_cnt_reg <= byte_cnt_next;
      wait_cnt_reg <= wait_cnt_next;
      ifg_cnt_reg  <= ifg_cnt_next;
    end
  end

  genvar gi;
  for (gi = 0; gi < 2; gi++) begin : g_frm_cnt
    // Per-source count of frames that ended cleanly; wraps.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        frm_cnt_reg[gi] <= '0;
      end else if (frm_inc[gi]) begin
        frm_cnt_reg[gi] <= frm_cnt_reg[gi] + 16'd1;
      end
    end
  end

  // Count of watchdog aborts from either source; wraps.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      abort_cnt_reg <= '0;
    end else if (abort_inc) begin
      abort_cnt_reg <= abort_cnt_reg + 16'd1;
    end
  end

  assign s0_gnt     = gnt_reg[0];
  assign s1_gnt     = gnt_reg[1];
  assign gmii_tx_en = out_reg.tx_en;
  assign gmii_tx_er = out_reg.tx_er;
  assign gmii_txd   = out_reg.txd;
  assign frm_cnt0   = frm_cnt_reg[0];
  assign frm_cnt1   = frm_cnt_reg[1];
  assign abort_cnt  = abort_cnt_reg;

endmodule

// File: tb/tb_tck7_gmii_tx_arbiter.sv
// Bench for the GMII TX arbiter: random frame contents, expected output
// stream and counters derived from the frame-level rules (one grant per
// frame, 1-cycle copy, poison byte after MAX_LEN, fixed idle gaps).
module tb_tck7_gmii_tx_arbiter;

  localparam int IFG_LEN   = 12;
  localparam int MAX_LEN   = 1526;
  localparam int START_TMO = 16;

  logic        clk = 1'b0;
  logic        reset_n;
  always #4 clk = ~clk;

  // Main DUT (fixed priority)
  logic [1:0]  req, tx_en, tx_er, gnt;
  logic [7:0]  txd [2];
  logic        gmii_tx_en, gmii_tx_er;
  logic [7:0]  gmii_txd;
  logic [15:0] frm_cnt0, frm_cnt1, abort_cnt;

  // Second DUT (round robin)
  logic [1:0]  rr_req, rr_tx_en, rr_gnt;
  logic [7:0]  rr_txd;
  logic        rr_gmii_tx_en, rr_gmii_tx_er;
  logic [7:0]  rr_gmii_txd;
  logic [15:0] rr_frm_cnt0, rr_frm_cnt1, rr_abort_cnt;

  tck7_gmii_tx_arbiter #(.ARB_MODE(0), .IFG_LEN(IFG_LEN), .MAX_LEN(MAX_LEN), .START_TMO(START_TMO)) u_dut (
    .clk(clk), .reset_n(reset_n),
    .s0_req(req[0]), .s0_gnt(gnt[0]), .s0_tx_en(tx_en[0]), .s0_tx_er(tx_er[0]), .s0_txd(txd[0]),
    .s1_req(req[1]), .s1_gnt(gnt[1]), .s1_tx_en(tx_en[1]), .s1_tx_er(tx_er[1]), .s1_txd(txd[1]),
    .gmii_tx_en(gmii_tx_en), .gmii_tx_er(gmii_tx_er), .gmii_txd(gmii_txd),
    .frm_cnt0(frm_cnt0), .frm_cnt1(frm_cnt1), .abort_cnt(abort_cnt)
  );

  tck7_gmii_tx_arbiter #(.ARB_MODE(1), .IFG_LEN(IFG_LEN), .MAX_LEN(MAX_LEN), .START_TMO(START_TMO)) u_dut_rr (
    .clk(clk), .reset_n(reset_n),
    .s0_req(rr_req[0]), .s0_gnt(rr_gnt[0]), .s0_tx_en(rr_tx_en[0]), .s0_tx_er(1'b0), .s0_txd(rr_txd),
    .s1_req(rr_req[1]), .s1_gnt(rr_gnt[1]), .s1_tx_en(rr_tx_en[1]), .s1_tx_er(1'b0), .s1_txd(rr_txd),
    .gmii_tx_en(rr_gmii_tx_en), .gmii_tx_er(rr_gmii_tx_er), .gmii_txd(rr_gmii_txd),
    .frm_cnt0(rr_frm_cnt0), .frm_cnt1(rr_frm_cnt1), .abort_cnt(rr_abort_cnt)
  );

  typedef struct packed {
    int         cyc;
    logic       er;
    logic [7:0] d;
  } byte_t;

  byte_t exp_q[$];
  byte_t got_q[$];
  int    edge_cnt = 0;
  int    compared = 0;
  int    mismatched = 0;
  int    exp_frm [2];
  int    exp_abort;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // Capture every byte the PCS would see, tagged with its cycle.
  always @(negedge clk) begin
    if (gmii_tx_en) got_q.push_back('{edge_cnt, gmii_tx_er, gmii_txd});
  end

  // Index of first disagreement, -2 on length mismatch, -1 if identical.
  // Data on a poisoned byte is not constrained.
  function automatic int first_diff();
    if (exp_q.size() != got_q.size()) return -2;
    foreach (exp_q[i]) begin
      if (exp_q[i].cyc != got_q[i].cyc || exp_q[i].er != got_q[i].er ||
          (!exp_q[i].er && exp_q[i].d != got_q[i].d)) return i;
    end
    return -1;
  endfunction

  task automatic wait_gnt(input int src, input int limit, output int n);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!gnt[src] && n < limit);
    if (!gnt[src]) n = -1;
  endtask

  task automatic settle();
    repeat (IFG_LEN + 4) @(posedge clk);
    #1;
  endtask

  // Called just after the grant becomes visible. Sends len bytes from src;
  // gsamples counts post-edge samples with the grant high.
  task automatic drive_frame(input int src, input int len, input bit noise, output int gsamples);
    int other;
    other = 1 - src;
    gsamples = gnt[src] ? 1 : 0;
    for (int i = 0; i < len; i++) begin
      tx_en[src] = 1'b1;
      txd[src]   = 8'($urandom);
      if (noise) begin
        tx_en[other] = 1'b1;
        tx_er[other] = 1'($urandom);
        txd[other]   = 8'($urandom);
      end
      if (i < MAX_LEN)       exp_q.push_back('{edge_cnt + 1, 1'b0, txd[src]});
      else if (i == MAX_LEN) exp_q.push_back('{edge_cnt + 1, 1'b1, txd[src]});
      @(posedge clk); #1;
      if (gnt[src]) gsamples++;
    end
    tx_en = 2'b00;
    tx_er = 2'b00;
    txd[0] = 8'h00;
    txd[1] = 8'h00;
    if (len > MAX_LEN) exp_abort++;
    else exp_frm[src]++;
    $display("frame src=%0d len=%0d noise=%0d gnt_samples=%0d", src, len, noise, gsamples);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    compared++; if (gnt !== 2'b00) begin mismatched++; $display("FAIL reset_gnt: got %b exp 00", gnt); end
    compared++; if (gmii_tx_en !== 1'b0) begin mismatched++; $display("FAIL reset_tx_en: got %b exp 0", gmii_tx_en); end
    compared++; if (gmii_tx_er !== 1'b0) begin mismatched++; $display("FAIL reset_tx_er: got %b exp 0", gmii_tx_er); end
    compared++; if (gmii_txd !== 8'h00) begin mismatched++; $display("FAIL reset_txd: got %h exp 00", gmii_txd); end
    compared++; if (frm_cnt0 !== 16'd0 || frm_cnt1 !== 16'd0) begin mismatched++; $display("FAIL reset_frm: got %0d/%0d exp 0/0", frm_cnt0, frm_cnt1); end
    compared++; if (abort_cnt !== 16'd0) begin mismatched++; $display("FAIL reset_abort: got %0d exp 0", abort_cnt); end
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk); #1;
    $display("reset released");
  endtask

  task automatic test_beacon();
    int n, g, sd, len2;
    exp_q.delete(); got_q.delete();
    req[0] = 1'b1;
    wait_gnt(0, 4, n);
    compared++; if (n != 1) begin mismatched++; $display("FAIL beacon_gnt_latency: got %0d exp 1", n); end
    req[0] = 1'b0;
    drive_frame(0, 194, 1'b0, g);
    compared++; if (g != 195) begin mismatched++; $display("FAIL beacon_gnt_len: got %0d exp 195", g); end
    req[0] = 1'b1;
    wait_gnt(0, 40, n);
    compared++; if (n != IFG_LEN + 2) begin mismatched++; $display("FAIL beacon_ifg: got %0d exp %0d", n, IFG_LEN + 2); end
    req[0] = 1'b0;
    len2 = $urandom_range(64, 100);
    drive_frame(0, len2, 1'b0, g);
    settle();
    sd = first_diff();
    compared++; if (sd != -1) begin mismatched++; $display("FAIL beacon_stream: got %0d bytes exp %0d, bad index %0d", got_q.size(), exp_q.size(), sd); end
    compared++; if (frm_cnt0 !== 16'(exp_frm[0])) begin mismatched++; $display("FAIL beacon_frm_cnt0: got %0d exp %0d", frm_cnt0, exp_frm[0]); end
  endtask

  task automatic test_fixed_prio();
    int n, g, sd;
    exp_q.delete(); got_q.delete();
    req = 2'b11;
    wait_gnt(0, 4, n);
    compared++; if (n != 1 || gnt[1] !== 1'b0) begin mismatched++; $display("FAIL prio_first: got n=%0d gnt=%b exp n=1 gnt=01", n, gnt); end
    req[0] = 1'b0;
    drive_frame(0, $urandom_range(60, 120), 1'b0, g);
    wait_gnt(1, 40, n);
    compared++; if (n != IFG_LEN + 2 || gnt[0] !== 1'b0) begin mismatched++; $display("FAIL prio_second: got n=%0d gnt=%b exp n=%0d gnt=10", n, gnt, IFG_LEN + 2); end
    req[1] = 1'b0;
    drive_frame(1, $urandom_range(60, 120), 1'b0, g);
    settle();
    sd = first_diff();
    compared++; if (sd != -1) begin mismatched++; $display("FAIL prio_stream: got %0d bytes exp %0d, bad index %0d", got_q.size(), exp_q.size(), sd); end
    compared++; if (frm_cnt0 !== 16'(exp_frm[0]) || frm_cnt1 !== 16'(exp_frm[1])) begin mismatched++; $display("FAIL prio_frm: got %0d/%0d exp %0d/%0d", frm_cnt0, frm_cnt1, exp_frm[0], exp_frm[1]); end
  endtask

  task automatic test_abort();
    int n, g, sd, f1_before;
    exp_q.delete(); got_q.delete();
    f1_before = exp_frm[1];
    req[1] = 1'b1;
    wait_gnt(1, 4, n);
    req[1] = 1'b0;
    drive_frame(1, 2000, 1'b0, g);
    compared++; if (g != MAX_LEN + 1) begin mismatched++; $display("FAIL abort_gnt_len: got %0d exp %0d", g, MAX_LEN + 1); end
    compared++; if (frm_cnt1 !== 16'(f1_before) || abort_cnt !== 16'(exp_abort)) begin mismatched++; $display("FAIL abort_cnts: got frm1=%0d abort=%0d exp %0d/%0d", frm_cnt1, abort_cnt, f1_before, exp_abort); end
    req[1] = 1'b1;
    wait_gnt(1, 40, n);
    compared++; if (n != IFG_LEN + 2) begin mismatched++; $display("FAIL abort_ifg: got %0d exp %0d", n, IFG_LEN + 2); end
    req[1] = 1'b0;
    drive_frame(1, 70, 1'b0, g);
    settle();
    sd = first_diff();
    compared++; if (sd != -1) begin mismatched++; $display("FAIL abort_stream: got %0d bytes exp %0d, bad index %0d", got_q.size(), exp_q.size(), sd); end
    compared++; if (frm_cnt1 !== 16'(exp_frm[1])) begin mismatched++; $display("FAIL abort_frm1: got %0d exp %0d", frm_cnt1, exp_frm[1]); end
  endtask

  task automatic test_timeout();
    int n, g, hi, sd;
    exp_q.delete(); got_q.delete();
    req = 2'b11;
    wait_gnt(0, 4, n);
    req[0] = 1'b0;
    hi = 1;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (gnt[0]) hi++;
      else break;
    end
    compared++; if (hi != START_TMO) begin mismatched++; $display("FAIL tmo_gnt_len: got %0d exp %0d", hi, START_TMO); end
    wait_gnt(1, 40, n);
    compared++; if (n != IFG_LEN + 1) begin mismatched++; $display("FAIL tmo_ifg: got %0d exp %0d", n, IFG_LEN + 1); end
    compared++; if (frm_cnt0 !== 16'(exp_frm[0]) || frm_cnt1 !== 16'(exp_frm[1]) || abort_cnt !== 16'(exp_abort)) begin
      mismatched++; $display("FAIL tmo_cnts: got %0d/%0d/%0d exp %0d/%0d/%0d", frm_cnt0, frm_cnt1, abort_cnt, exp_frm[0], exp_frm[1], exp_abort);
    end
    req[1] = 1'b0;
    drive_frame(1, 60, 1'b0, g);
    settle();
    sd = first_diff();
    compared++; if (sd != -1) begin mismatched++; $display("FAIL tmo_stream: got %0d bytes exp %0d, bad index %0d", got_q.size(), exp_q.size(), sd); end
  endtask

  task automatic test_isolation();
    int n, g, sd;
    exp_q.delete(); got_q.delete();
    req[0] = 1'b1;
    wait_gnt(0, 4, n);
    req[0] = 1'b0;
    drive_frame(0, $urandom_range(80, 200), 1'b1, g);
    settle();
    sd = first_diff();
    compared++; if (sd != -1) begin mismatched++; $display("FAIL isolation_stream: got %0d bytes exp %0d, bad index %0d", got_q.size(), exp_q.size(), sd); end
  endtask

  task automatic test_round_robin();
    int last_served, w, exp_w, len;
    int rr_exp [2];
    rr_exp[0] = 0;
    rr_exp[1] = 0;
    last_served = 1;
    rr_req = 2'b11;
    for (int k = 0; k < 4; k++) begin
      w = -1;
      for (int t = 0; t < 60; t++) begin
        @(posedge clk); #1;
        if (rr_gnt != 2'b00) begin
          w = rr_gnt[1] ? 1 : 0;
          break;
        end
      end
      exp_w = 1 - last_served;
      compared++; if (w != exp_w) begin mismatched++; $display("FAIL rr_winner_%0d: got %0d exp %0d", k, w, exp_w); end
      if (w < 0) break;
      len = $urandom_range(20, 40);
      for (int i = 0; i < len; i++) begin
        rr_tx_en[w] = 1'b1;
        rr_txd = 8'($urandom);
        @(posedge clk); #1;
      end
      rr_tx_en = 2'b00;
      rr_exp[w]++;
      last_served = w;
      $display("rr frame %0d src=%0d len=%0d", k, w, len);
    end
    rr_req = 2'b00;
    settle();
    compared++; if (rr_frm_cnt0 !== 16'(rr_exp[0]) || rr_frm_cnt1 !== 16'(rr_exp[1])) begin
      mismatched++; $display("FAIL rr_frm: got %0d/%0d exp %0d/%0d", rr_frm_cnt0, rr_frm_cnt1, rr_exp[0], rr_exp[1]);
    end
  endtask

  task automatic test_reset_midframe();
    int n, g, sd;
    req[0] = 1'b1;
    wait_gnt(0, 4, n);
    req[0] = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tx_en[0] = 1'b1;
      txd[0] = 8'($urandom);
      @(posedge clk); #1;
    end
    #2;
    reset_n = 1'b0;
    #1;
    compared++; if (gmii_tx_en !== 1'b0 || gnt !== 2'b00) begin mismatched++; $display("FAIL midreset_out: got tx_en=%b gnt=%b exp 0/00", gmii_tx_en, gnt); end
    compared++; if (frm_cnt0 !== 16'd0 || frm_cnt1 !== 16'd0 || abort_cnt !== 16'd0) begin
      mismatched++; $display("FAIL midreset_cnts: got %0d/%0d/%0d exp 0/0/0", frm_cnt0, frm_cnt1, abort_cnt);
    end
    exp_frm[0] = 0;
    exp_frm[1] = 0;
    exp_abort  = 0;
    tx_en[0] = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk); #1;
    exp_q.delete(); got_q.delete();
    req[0] = 1'b1;
    wait_gnt(0, 4, n);
    compared++; if (n != 1) begin mismatched++; $display("FAIL midreset_regrant: got %0d exp 1", n); end
    req[0] = 1'b0;
    drive_frame(0, $urandom_range(64, 128), 1'b0, g);
    settle();
    sd = first_diff();
    compared++; if (sd != -1) begin mismatched++; $display("FAIL midreset_stream: got %0d bytes exp %0d, bad index %0d", got_q.size(), exp_q.size(), sd); end
    compared++; if (frm_cnt0 !== 16'(exp_frm[0])) begin mismatched++; $display("FAIL midreset_frm0: got %0d exp %0d", frm_cnt0, exp_frm[0]); end
  endtask

  initial begin
    reset_n  = 1'b0;
    req      = 2'b00;
    tx_en    = 2'b00;
    tx_er    = 2'b00;
    txd[0]   = 8'h00;
    txd[1]   = 8'h00;
    rr_req   = 2'b00;
    rr_tx_en = 2'b00;
    rr_txd   = 8'h00;
    exp_frm[0] = 0;
    exp_frm[1] = 0;
    exp_abort  = 0;

    test_reset();
    test_beacon();
    test_fixed_prio();
    test_abort();
    test_timeout();
    test_isolation();
    test_round_robin();
    test_reset_midframe();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
